// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of mem_arbiter; slave = arbiter view,
// master = the surrounding requesters plus the memory wrapper.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  done0, done1;
    logic                  err0, err1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_addr, mem_data, mem_we, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_addr, mem_data, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between two requesters, one access in flight.
// Latency: gnt one cycle after the sampling edge, done/err/rdata three cycles after; one access per 3 cycles.
// Backpressure: requesters hold req until gnt; requests are ignored while busy. MEM_ARB_RR_EN selects round-robin, else port 0 priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX = 16'h03FF
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic                  start;
    logic                  win;          // 0 = port 0, 1 = port 1
    logic                  contend_win;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    logic                  sel_oor;
    logic                  cur_port;
    logic                  cur_err;
    logic                  cur_we;

`ifdef MEM_ARB_RR_EN
    logic last_port;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_port <= 1'b1;
        end else if (start) begin
            last_port <= win;
        end
    end

    assign contend_win = ~last_port;
`else
    assign contend_win = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                    win       = (bus.req0 && bus.req1) ? contend_win : bus.req1;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sel_addr  = win ? bus.addr1  : bus.addr0;
        sel_wdata = win ? bus.wdata1 : bus.wdata0;
        sel_we    = win ? bus.we1    : bus.we0;
    end

    assign sel_oor  = (sel_addr > ADDR_MAX);
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.done1    <= 1'b0;
            bus.err0     <= 1'b0;
            bus.err1     <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.mem_we   <= 1'b0;
            cur_port     <= 1'b0;
            cur_err      <= 1'b0;
            cur_we       <= 1'b0;
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.mem_addr <= sel_addr;
                        bus.mem_data <= sel_wdata;
                        // out-of-range writes are granted but never reach the memory
                        bus.mem_we   <= sel_we & ~sel_oor;
                        bus.gnt0     <= ~win;
                        bus.gnt1     <= win;
                        cur_port     <= win;
                        cur_err      <= sel_oor;
                        cur_we       <= sel_we;
                    end
                end
                ACCESS: begin
                    bus.mem_we <= 1'b0;
                end
                RESP: begin
                    if (cur_port) begin
                        bus.done1  <= 1'b1;
                        bus.err1   <= cur_err;
                        bus.rdata1 <= (cur_err || cur_we) ? '0 : bus.mem_q;
                    end else begin
                        bus.done0  <= 1'b1;
                        bus.err0   <= cur_err;
                        bus.rdata0 <= (cur_err || cur_we) ? '0 : bus.mem_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
